// File: rtl/hazard_stall_controller_pkg.sv
// ----------------------------------------------------------------------------
// arm_pipe_pkg
// Shared LEGv8 pipeline definitions: opcode match constants, the zero
// register index and the sequencing-controller state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package arm_pipe_pkg;

    // Opcode match values, compared against the upper instruction bits
    localparam logic [5:0]  OP_B       = 6'b000101;      // [31:26]
    localparam logic [7:0]  OP_CBZ     = 8'hB4;          // [31:24]
    localparam logic [10:0] OP_STUR    = 11'h7C0;        // [31:21]
    localparam logic [10:0] OP_LDUR    = 11'h7C2;        // [31:21]
    localparam logic [2:0]  OP_R_CLASS = 3'b101;         // [27:25]

    localparam logic [4:0]  XZR_IDX    = 5'd31;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    // Plain-constant view of the state encoding for legacy consumers
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_controller_if
// Bundles the pipeline-side inputs and control outputs of the hazard/stall
// controller.
//   master : pipeline side, drives instruction/load/branch/clear inputs
//   slave  : controller side, drives enables, bubble, flushes and counters
// ----------------------------------------------------------------------------
interface hazard_stall_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      if_id_instr;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rd;
    logic             branch_taken;
    logic             cnt_clr;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             stall_active;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output if_id_instr, id_ex_mem_read, id_ex_rd, branch_taken, cnt_clr,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
               exmem_flush, stall_active, stall_count, flush_count
    );

    modport slave (
        input  if_id_instr, id_ex_mem_read, id_ex_rd, branch_taken, cnt_clr,
        output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
               exmem_flush, stall_active, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_stall_controller_decode.sv
// ----------------------------------------------------------------------------
// operand_use_decode
// Combinational source-operand decode of a LEGv8 instruction. Also used by
// the forwarding unit.
//   if_id_instr_i : instruction word
//   uses_rn_o/rm_o/rt_o : which register fields are read as sources
//   rn_o/rm_o/rt_o      : the register fields themselves
// ----------------------------------------------------------------------------
module operand_use_decode
    import arm_pipe_pkg::*;
(
    input  logic [31:0] if_id_instr_i,
    output logic        uses_rn_o,
    output logic        uses_rm_o,
    output logic        uses_rt_o,
    output logic [4:0]  rn_o,
    output logic [4:0]  rm_o,
    output logic [4:0]  rt_o
);
    logic is_b;
    logic is_cbz;
    logic is_stur;
    logic unused_imm;

    assign is_b    = (if_id_instr_i[31:26] == OP_B);
    assign is_cbz  = (if_id_instr_i[31:24] == OP_CBZ);
    assign is_stur = (if_id_instr_i[31:21] == OP_STUR);

    assign rn_o = if_id_instr_i[9:5];
    assign rm_o = if_id_instr_i[20:16];
    assign rt_o = if_id_instr_i[4:0];

    // B has no register operands; CBZ tests Rt, not Rn
    assign uses_rn_o = !is_b && !is_cbz;
    assign uses_rm_o = (if_id_instr_i[27:25] == OP_R_CLASS);
    // STUR reads Rt as store data; CBZ reads Rt as the tested register
    assign uses_rt_o = is_stur || is_cbz;

    // Shamt/immediate bits carry no register information
    assign unused_imm = ^if_id_instr_i[15:10];
endmodule

// File: rtl/hazard_stall_controller.sv
// ----------------------------------------------------------------------------
// hazard_stall_controller
// Load-use hazard detection and taken-branch flush sequencing for the 5-stage
// LEGv8 pipeline, with saturating stall/flush performance counters.
//   clk : pipeline clock
//   rst : asynchronous active-high reset
//   bus : hazard_stall_controller_if.slave (instruction/load/branch inputs,
//         enable/bubble/flush outputs, counters)
//
// state | meaning
// ------+-------------------------------------------------------------------
// RUN   | no hazard in progress; first bubble of a hazard is issued from here
// STALL | extra bubbles for slow loads; cnt_q counts remaining cycles down
// ----------------------------------------------------------------------------
module hazard_stall_controller
    import arm_pipe_pkg::*;
#(
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    hazard_stall_controller_if.slave   bus
);
    logic [0:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] flush_count_q;

    logic             uses_rn, uses_rm, uses_rt;
    logic [4:0]       rn, rm, rt;
    logic             hz;

    logic             pc_write, ifid_write, idex_bubble, stall_active;
    logic             flush;

    operand_use_decode u_decode (
        .if_id_instr_i (bus.if_id_instr),
        .uses_rn_o     (uses_rn),
        .uses_rm_o     (uses_rm),
        .uses_rt_o     (uses_rt),
        .rn_o          (rn),
        .rm_o          (rm),
        .rt_o          (rt)
    );

    assign hz = bus.id_ex_mem_read && (bus.id_ex_rd != XZR_IDX) &&
                ((uses_rn && (rn == bus.id_ex_rd)) ||
                 (uses_rm && (rm == bus.id_ex_rd)) ||
                 (uses_rt && (rt == bus.id_ex_rd)));

    // Reset is async, so outputs are gated by rst directly rather than
    // waiting for the state register to settle.
    assign flush = bus.branch_taken && !rst;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_bubble  = 1'b0;
        stall_active = 1'b0;

        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (!bus.branch_taken && hz) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_bubble  = 1'b1;
                        stall_active = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = 4'(LOAD_STALL - 1);
                        end
                    end
                end
                ST_STALL: begin
                    if (bus.branch_taken) begin
                        // Abort: keep PC/IF-ID enabled so the redirect
                        // target is fetched; idex_flush does the squash.
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_bubble  = 1'b1;
                        stall_active = 1'b1;
                        if (cnt_q == 4'd1) begin
                            state_d = ST_RUN;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else if (bus.cnt_clr) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (stall_active && (stall_count_q != '1))
                stall_count_q <= stall_count_q + 1'b1;
            if (bus.branch_taken && (flush_count_q != '1))
                flush_count_q <= flush_count_q + 1'b1;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.ifid_write   = ifid_write;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.stall_active = stall_active;
    assign bus.ifid_flush   = flush;
    assign bus.idex_flush   = flush;
    assign bus.exmem_flush  = flush;
    assign bus.stall_count  = stall_count_q;
    assign bus.flush_count  = flush_count_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // A: single-bubble loads, wide counters.  B: 3-cycle loads, 4-bit counters.
    hazard_stall_controller_if #(.CNT_W(16)) ifa ();
    hazard_stall_controller_if #(.CNT_W(4))  ifb ();

    hazard_stall_controller #(.LOAD_STALL(1), .CNT_W(16)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa));
    hazard_stall_controller #(.LOAD_STALL(3), .CNT_W(4)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb));

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADD_X3_X1_X4 = 32'h8B040023;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic seta(input logic [31:0] ins, input logic mr, input logic [4:0] rd,
                        input logic bt, input logic clr);
        ifa.if_id_instr = ins; ifa.id_ex_mem_read = mr; ifa.id_ex_rd = rd;
        ifa.branch_taken = bt; ifa.cnt_clr = clr;
    endtask

    task automatic setb(input logic [31:0] ins, input logic mr, input logic [4:0] rd,
                        input logic bt, input logic clr);
        ifb.if_id_instr = ins; ifb.id_ex_mem_read = mr; ifb.id_ex_rd = rd;
        ifb.branch_taken = bt; ifb.cnt_clr = clr;
    endtask

    // Reference hazard rule, from the operand-use table
    function automatic bit m_hz(input logic [31:0] ins, input bit mr, input logic [4:0] rd);
        int used[$];
        bit is_b, is_cbz, is_stur, is_r;
        is_b    = (ins[31:26] == 6'b000101);
        is_cbz  = (ins[31:24] == 8'hB4);
        is_stur = (ins[31:21] == 11'h7C0);
        is_r    = (ins[27:25] == 3'b101);
        if (!is_b && !is_cbz)  used.push_back(int'(ins[9:5]));
        if (is_r)              used.push_back(int'(ins[20:16]));
        if (is_stur || is_cbz) used.push_back(int'(ins[4:0]));
        if (!mr || rd == 5'd31) return 1'b0;
        foreach (used[j]) if (used[j] == int'(rd)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [4:0] rnd_reg();
        int v;
        v = int'($urandom % 6);
        return (v == 5) ? 5'd31 : 5'(v);
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 6)
            0: return {11'b10001011000, rnd_reg(), r[15:10], rnd_reg(), rnd_reg()};
            1: return {6'b000101, r[25:0]};
            2: return {8'hB4, r[23:5], rnd_reg()};
            3: return {11'h7C0, r[20:12], 2'b00, rnd_reg(), rnd_reg()};
            4: return {11'h7C2, r[20:12], 2'b00, rnd_reg(), rnd_reg()};
            default: return r;
        endcase
    endfunction

    typedef struct {
        logic [31:0] ins;
        logic        mr;
        logic [4:0]  rd;
        logic        bt;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[$];

    // Random-phase model state: [0]=A, [1]=B
    int ls[2]   = '{1, 3};
    int maxc[2] = '{65535, 15};
    int rem[2], sc[2], fc[2];

    initial begin
        int exp_sc, exp_fc;

        // ---------------- reset overrides a live hazard and branch -----------
        rst = 1'b1;
        seta(ADD_X3_X1_X4, 1'b1, 5'd1, 1'b1, 1'b0);
        setb(ADD_X3_X1_X4, 1'b1, 5'd1, 1'b0, 1'b0);
        #12;
        chk("rst_pc_write",   {31'd0, ifa.pc_write},    32'd1);
        chk("rst_ifid_write", {31'd0, ifa.ifid_write},  32'd1);
        chk("rst_bubble",     {31'd0, ifa.idex_bubble}, 32'd0);
        chk("rst_flush",      {31'd0, ifa.idex_flush},  32'd0);
        chk("rst_stall_b",    {31'd0, ifb.stall_active},32'd0);
        chk("rst_cnt",        32'(ifa.stall_count) + 32'(ifa.flush_count), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        seta(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        setb(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        // ---------------- decode/hazard table on A (LOAD_STALL=1) ------------
        vecs.push_back('{ADD_X3_X1_X4, 1'b1, 5'd1,  1'b0, 1'b1}); // rn hit
        vecs.push_back('{ADD_X3_X1_X4, 1'b0, 5'd1,  1'b0, 1'b0}); // load gone
        vecs.push_back('{ADD_X3_X1_X4, 1'b1, 5'd4,  1'b0, 1'b1}); // rm hit
        vecs.push_back('{ADD_X3_X1_X4, 1'b1, 5'd3,  1'b0, 1'b0}); // rt not read by ADD
        vecs.push_back('{32'h8B0403E3, 1'b1, 5'd31, 1'b0, 1'b0}); // XZR never hazards
        vecs.push_back('{32'h14000004, 1'b1, 5'd0,  1'b0, 1'b0}); // B uses no regs
        vecs.push_back('{32'hB4000045, 1'b1, 5'd5,  1'b0, 1'b1}); // CBZ rt hit
        vecs.push_back('{32'hB4000045, 1'b1, 5'd2,  1'b0, 1'b0}); // CBZ ignores rn
        vecs.push_back('{32'hF8000047, 1'b1, 5'd7,  1'b0, 1'b1}); // STUR rt hit
        vecs.push_back('{32'hF8000047, 1'b1, 5'd2,  1'b0, 1'b1}); // STUR rn hit
        vecs.push_back('{32'hF8400047, 1'b1, 5'd7,  1'b0, 1'b0}); // LDUR rt is dest
        vecs.push_back('{32'hF8400047, 1'b1, 5'd2,  1'b0, 1'b1}); // LDUR rn hit
        vecs.push_back('{ADD_X3_X1_X4, 1'b1, 5'd1,  1'b1, 1'b0}); // branch wins

        exp_sc = 0; exp_fc = 0;
        foreach (vecs[i]) begin
            @(negedge clk);
            seta(vecs[i].ins, vecs[i].mr, vecs[i].rd, vecs[i].bt, 1'b0);
            #1;
            chk($sformatf("tab%0d_pc", i),     {31'd0, ifa.pc_write},     {31'd0, ~vecs[i].exp_stall});
            chk($sformatf("tab%0d_ifid", i),   {31'd0, ifa.ifid_write},   {31'd0, ~vecs[i].exp_stall});
            chk($sformatf("tab%0d_bubble", i), {31'd0, ifa.idex_bubble},  {31'd0, vecs[i].exp_stall});
            chk($sformatf("tab%0d_stall", i),  {31'd0, ifa.stall_active}, {31'd0, vecs[i].exp_stall});
            chk($sformatf("tab%0d_flush", i),  {29'd0, ifa.ifid_flush, ifa.idex_flush, ifa.exmem_flush},
                                               {29'd0, {3{vecs[i].bt}}});
            chk($sformatf("tab%0d_scnt", i),   32'(ifa.stall_count), 32'(exp_sc));
            if (vecs[i].exp_stall) exp_sc++;
            if (vecs[i].bt) exp_fc++;
        end
        @(negedge clk);
        seta(32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("tab_final_scnt", 32'(ifa.stall_count), 32'(exp_sc));
        chk("tab_final_fcnt", 32'(ifa.flush_count), 32'(exp_fc));

        // ---------------- B: three-cycle load stall -------------------------
        @(negedge clk); setb(ADD_X3_X1_X4, 1'b1, 5'd1, 1'b0, 1'b0); #1;
        chk("ls3_n0_stall", {31'd0, ifb.stall_active}, 32'd1);
        @(negedge clk); setb(ADD_X3_X1_X4, 1'b0, 5'd1, 1'b0, 1'b0); #1;
        chk("ls3_n1_stall", {31'd0, ifb.stall_active}, 32'd1);
        chk("ls3_n1_pc",    {31'd0, ifb.pc_write},     32'd0);
        @(negedge clk); #1;
        chk("ls3_n2_stall", {31'd0, ifb.stall_active}, 32'd1);
        @(negedge clk); #1;
        chk("ls3_n3_stall", {31'd0, ifb.stall_active}, 32'd0);
        chk("ls3_n3_pc",    {31'd0, ifb.pc_write},     32'd1);
        chk("ls3_scnt",     32'(ifb.stall_count),      32'd3);

        // ---------------- B: branch aborts a stall --------------------------
        @(negedge clk); setb(32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        @(negedge clk); setb(ADD_X3_X1_X4, 1'b1, 5'd1, 1'b0, 1'b0); #1;
        chk("abort_n0_stall", {31'd0, ifb.stall_active}, 32'd1);
        @(negedge clk); setb(ADD_X3_X1_X4, 1'b0, 5'd1, 1'b1, 1'b0); #1;
        chk("abort_n1_flush", {29'd0, ifb.ifid_flush, ifb.idex_flush, ifb.exmem_flush}, 32'd7);
        chk("abort_n1_pc",    {30'd0, ifb.pc_write, ifb.ifid_write}, 32'd3);
        chk("abort_n1_bubble",{31'd0, ifb.idex_bubble},  32'd0);
        chk("abort_n1_stall", {31'd0, ifb.stall_active}, 32'd0);
        @(negedge clk); setb(ADD_X3_X1_X4, 1'b0, 5'd1, 1'b0, 1'b0); #1;
        chk("abort_n2_stall", {31'd0, ifb.stall_active}, 32'd0);
        chk("abort_n2_fcnt",  32'(ifb.flush_count), 32'd1);
        chk("abort_n2_scnt",  32'(ifb.stall_count), 32'd1);

        // ---------------- B: 4-bit counter saturation and clear --------------
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); setb(32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        end
        @(negedge clk); setb(32'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
        chk("sat_fcnt", 32'(ifb.flush_count), 32'd15);
        @(negedge clk); setb(32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        @(negedge clk); setb(32'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
        chk("clr_fcnt", 32'(ifb.flush_count), 32'd0);
        chk("clr_scnt", 32'(ifb.stall_count), 32'd0);

        // ---------------- B: async reset in the middle of a stall ------------
        @(negedge clk); setb(ADD_X3_X1_X4, 1'b1, 5'd1, 1'b0, 1'b0);
        @(negedge clk); setb(ADD_X3_X1_X4, 1'b0, 5'd1, 1'b0, 1'b0); #1;
        chk("arst_pre_stall", {31'd0, ifb.stall_active}, 32'd1);
        #2; rst = 1'b1; ifb.branch_taken = 1'b1; #1;
        chk("arst_stall",  {31'd0, ifb.stall_active}, 32'd0);
        chk("arst_pc",     {30'd0, ifb.pc_write, ifb.ifid_write}, 32'd3);
        chk("arst_flush",  {31'd0, ifb.exmem_flush}, 32'd0);
        chk("arst_scnt",   32'(ifb.stall_count), 32'd0);
        @(negedge clk); rst = 1'b0; setb(ADD_X3_X1_X4, 1'b0, 5'd1, 1'b0, 1'b0); #1;
        chk("arst_after_stall", {31'd0, ifb.stall_active}, 32'd0);

        // ---------------- randomized run against the reference model ---------
        for (int k = 0; k < 2; k++) begin rem[k] = 0; sc[k] = 0; fc[k] = 0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [31:0] ins;
            logic [4:0]  rd;
            logic        mr, bt, clr;
            logic        a_pc[2], a_bub[2], a_st[2], a_fl[2];
            int          a_sc[2], a_fc[2];
            @(negedge clk);
            ins = rnd_instr();
            rd  = rnd_reg();
            mr  = ($urandom % 2) == 0;
            bt  = ($urandom % 10) == 0;
            clr = ($urandom % 40) == 0;
            rst = (cyc == 0) || (($urandom % 60) == 0);
            seta(ins, mr, rd, bt, clr);
            setb(ins, mr, rd, bt, clr);
            #1;
            a_pc[0] = ifa.pc_write; a_bub[0] = ifa.idex_bubble; a_st[0] = ifa.stall_active;
            a_fl[0] = ifa.idex_flush; a_sc[0] = 32'(ifa.stall_count); a_fc[0] = 32'(ifa.flush_count);
            a_pc[1] = ifb.pc_write; a_bub[1] = ifb.idex_bubble; a_st[1] = ifb.stall_active;
            a_fl[1] = ifb.idex_flush; a_sc[1] = 32'(ifb.stall_count); a_fc[1] = 32'(ifb.flush_count);
            for (int k = 0; k < 2; k++) begin
                bit e_st, e_fl;
                int nrem;
                if (rst) begin
                    rem[k] = 0; sc[k] = 0; fc[k] = 0;
                    e_st = 1'b0; e_fl = 1'b0; nrem = 0;
                end else begin
                    e_fl = bt;
                    if (bt)                      begin e_st = 1'b0; nrem = 0; end
                    else if (rem[k] > 0)         begin e_st = 1'b1; nrem = rem[k] - 1; end
                    else if (m_hz(ins, mr, rd))  begin e_st = 1'b1; nrem = ls[k] - 1; end
                    else                         begin e_st = 1'b0; nrem = 0; end
                end
                chk($sformatf("rnd%0d_k%0d_pc", cyc, k),    {31'd0, a_pc[k]},  {31'd0, ~e_st});
                chk($sformatf("rnd%0d_k%0d_bub", cyc, k),   {31'd0, a_bub[k]}, {31'd0, e_st});
                chk($sformatf("rnd%0d_k%0d_stall", cyc, k), {31'd0, a_st[k]},  {31'd0, e_st});
                chk($sformatf("rnd%0d_k%0d_flush", cyc, k), {31'd0, a_fl[k]},  {31'd0, e_fl});
                chk($sformatf("rnd%0d_k%0d_scnt", cyc, k),  a_sc[k], sc[k]);
                chk($sformatf("rnd%0d_k%0d_fcnt", cyc, k),  a_fc[k], fc[k]);
                if (!rst) begin
                    rem[k] = nrem;
                    if (clr) begin
                        sc[k] = 0; fc[k] = 0;
                    end else begin
                        if (e_st && sc[k] < maxc[k]) sc[k]++;
                        if (bt && fc[k] < maxc[k])   fc[k]++;
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
